// File: rtl/axil_mem_master.sv
// AXI4-lite master serving instruction-fetch and data load/store request ports.
// Optional watchdog enabled by defining AXIL_MEM_TIMEOUT_EN.
module axil_mem_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  output logic                ireq_ready,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                irsp_valid,
  output logic [DATA_W-1:0]   irsp_data,
  output logic                irsp_err,
  input  logic                dreq_valid,
  output logic                dreq_ready,
  input  logic                dreq_write,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [DATA_W-1:0]   dreq_wdata,
  input  logic [DATA_W/8-1:0] dreq_wstrb,
  output logic                drsp_valid,
  output logic [DATA_W-1:0]   drsp_data,
  output logic                drsp_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddress,
  output logic [2:0]          awprot,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wrstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddress,
  output logic [2:0]          arprot,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RSP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                instr_q, instr_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout;

  function automatic logic resp_err(input logic [1:0] resp);
    return !(resp == 2'b00 || resp == 2'b01);
  endfunction

`ifdef AXIL_MEM_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (state_q != IDLE) && (state_q != RSP) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Counter restarts on every state change so each bus phase gets the full budget.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && state_q != IDLE && state_q != RSP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    instr_d    = instr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ireq_ready = 1'b0;
    dreq_ready = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    irsp_valid = 1'b0;
    drsp_valid = 1'b0;

    if (timeout) begin
      state_d    = RSP;
      rsp_data_d = '0;
      rsp_err_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq_valid) begin
            dreq_ready = 1'b1;
            addr_d     = dreq_addr;
            wdata_d    = dreq_wdata;
            wstrb_d    = dreq_wstrb;
            instr_d    = 1'b0;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            if (dreq_addr[LSB_W-1:0] != '0) begin
              state_d    = RSP;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end else begin
              state_d = dreq_write ? AW_W : AR;
            end
          end else if (ireq_valid) begin
            ireq_ready = 1'b1;
            addr_d     = ireq_addr;
            wdata_d    = '0;
            wstrb_d    = '0;
            instr_d    = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            if (ireq_addr[LSB_W-1:0] != '0) begin
              state_d    = RSP;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end else begin
              state_d = AR;
            end
          end
        end
        AR: begin
          arvalid = 1'b1;
          if (arready) state_d = R;
        end
        R: begin
          rready = 1'b1;
          if (rvalid) begin
            state_d    = RSP;
            rsp_err_d  = resp_err(rresp);
            rsp_data_d = resp_err(rresp) ? '0 : rdata;
          end
        end
        AW_W: begin
          // Each channel drops its valid on its own handshake; move on once both are done.
          awvalid   = !aw_done_q;
          wvalid    = !w_done_q;
          aw_done_d = aw_done_q || awready;
          w_done_d  = w_done_q || wready;
          if (aw_done_d && w_done_d) state_d = B;
        end
        B: begin
          bready = 1'b1;
          if (bvalid) begin
            state_d    = RSP;
            rsp_err_d  = resp_err(bresp);
            rsp_data_d = '0;
          end
        end
        RSP: begin
          irsp_valid = instr_q;
          drsp_valid = !instr_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign araddress = addr_q;
  assign awaddress = addr_q;
  assign wdata     = wdata_q;
  assign wrstrb    = wstrb_q;
  assign arprot    = (state_q == AR && instr_q) ? 3'b101 : 3'b000;
  assign awprot    = 3'b000;
  assign irsp_data = irsp_valid ? rsp_data_q : '0;
  assign irsp_err  = irsp_valid & rsp_err_q;
  assign drsp_data = drsp_valid ? rsp_data_q : '0;
  assign drsp_err  = drsp_valid & rsp_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      instr_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      instr_q    <= instr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_axil_mem_master.sv
// Self-checking bench for axil_mem_master: directed steps plus randomized traffic
// against a memory-level reference model and a configurable-latency AXI-lite slave.
module tb_axil_mem_master;

`ifdef AXIL_MEM_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid, ireq_ready, irsp_valid, irsp_err;
  logic [31:0] ireq_addr, irsp_data;
  logic        dreq_valid, dreq_ready, dreq_write, drsp_valid, drsp_err;
  logic [31:0] dreq_addr, dreq_wdata, drsp_data;
  logic [3:0]  dreq_wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddress, wdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wrstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddress, rdata;

  always #5 clk = ~clk;

  axil_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
    .irsp_valid(irsp_valid), .irsp_data(irsp_data), .irsp_err(irsp_err),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_write(dreq_write),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
    .drsp_valid(drsp_valid), .drsp_data(drsp_data), .drsp_err(drsp_err),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wrstrb(wrstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int checks = 0;
  int errors = 0;

  // Slave configuration and handshake logs.
  int          cfg_ar_d = 0, cfg_r_d = 0, cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [34:0] ar_log[$];
  logic [34:0] aw_log[$];
  logic [35:0] w_log[$];
  logic [31:0] smem[logic [31:0]];
  logic [31:0] rmem[logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a << 16) | 32'h0000_0013;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                       input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] srd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  function automatic logic resp_bad(input logic [1:0] r);
    return !(r == 2'b00 || r == 2'b01);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI-lite slave: decides handshakes at the falling edge from registered master outputs.
  initial begin : slave
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic rd_pend, aw_got, w_got;
    logic [31:0] rd_a, wr_a, wr_d;
    logic [3:0]  wr_s;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_pend = 0; aw_got = 0; w_got = 0; rd_a = 0; wr_a = 0; wr_d = 0; wr_s = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      if (!reset) begin
        rd_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        if (arvalid && !rd_pend) begin
          if (ar_cnt >= cfg_ar_d) begin
            arready = 1; rd_pend = 1; rd_a = araddress; ar_cnt = 0; r_cnt = 0;
            ar_log.push_back({arprot, araddress});
          end else ar_cnt++;
        end else ar_cnt = 0;
        if (rd_pend && rready) begin
          if (r_cnt >= cfg_r_d) begin
            rvalid = 1; rresp = cfg_resp; rdata = srd(rd_a); rd_pend = 0;
          end else r_cnt++;
        end
        if (awvalid && !aw_got) begin
          if (aw_cnt >= cfg_aw_d) begin
            awready = 1; aw_got = 1; wr_a = awaddress; aw_cnt = 0;
            aw_log.push_back({awprot, awaddress});
          end else aw_cnt++;
        end else aw_cnt = 0;
        if (wvalid && !w_got) begin
          if (w_cnt >= cfg_w_d) begin
            wready = 1; w_got = 1; wr_d = wdata; wr_s = wrstrb; w_cnt = 0;
            w_log.push_back({wrstrb, wdata});
          end else w_cnt++;
        end else w_cnt = 0;
        if (aw_got && w_got && bready) begin
          if (b_cnt >= cfg_b_d) begin
            bvalid = 1; bresp = cfg_resp; aw_got = 0; w_got = 0; b_cnt = 0;
            if (!resp_bad(cfg_resp)) smem[wr_a] = merge(srd(wr_a), wr_d, wr_s);
          end else b_cnt++;
        end
      end
    end
  end

  // One complete request on either port, checked against timing and memory rules.
  task automatic run_req(input logic is_i, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [1:0] resp);
    int n, ar_c, aw_c, w_c, nar0, naw0, lat, mx;
    logic mis, bad, rd_ok;
    logic [31:0] exp_d;
    mis   = (addr[1:0] != 2'b00);
    bad   = mis || resp_bad(resp);
    rd_ok = !mis && !wr;
    mx    = (cfg_aw_d > cfg_w_d) ? cfg_aw_d : cfg_w_d;
    lat   = mis ? 1 : (wr ? 3 + mx + cfg_b_d : 3 + cfg_ar_d + cfg_r_d);
    exp_d = (bad || wr) ? 32'h0 : rd_ref(addr);
    cfg_resp = resp;
    nar0 = ar_log.size();
    naw0 = aw_log.size() + w_log.size();
    @(negedge clk);
    if (is_i) begin
      ireq_valid = 1; ireq_addr = addr;
    end else begin
      dreq_valid = 1; dreq_write = wr; dreq_addr = addr; dreq_wdata = wd; dreq_wstrb = ws;
    end
    #1;
    n = 0;
    while (!(is_i ? ireq_ready : dreq_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("accept", {ireq_ready, dreq_ready}, is_i ? 2'b10 : 2'b01);
    @(negedge clk);
    ireq_valid = 0; dreq_valid = 0;
    #1;
    n = 1; ar_c = 0; aw_c = 0; w_c = 0;
    while (!(irsp_valid || drsp_valid) && n < 200) begin
      ar_c += int'(arvalid); aw_c += int'(awvalid); w_c += int'(wvalid);
      @(negedge clk); #1; n++;
    end
    check("latency", n, lat);
    check("rsp_chan", {irsp_valid, drsp_valid}, is_i ? 2'b10 : 2'b01);
    check("rsp_data", is_i ? irsp_data : drsp_data, exp_d);
    check("rsp_err", is_i ? irsp_err : drsp_err, bad);
    check("valid_cycles", {ar_c[7:0], aw_c[7:0], w_c[7:0]},
          {rd_ok ? 8'(cfg_ar_d + 1) : 8'd0,
           (!mis && wr) ? 8'(cfg_aw_d + 1) : 8'd0,
           (!mis && wr) ? 8'(cfg_w_d + 1) : 8'd0});
    check("ar_count", ar_log.size() - nar0, rd_ok ? 1 : 0);
    check("aw_w_count", aw_log.size() + w_log.size() - naw0, (!mis && wr) ? 2 : 0);
    if (rd_ok) check("ar_fields", ar_log[$], {is_i ? 3'b101 : 3'b000, addr});
    if (!mis && wr) begin
      check("aw_fields", aw_log[$], {3'b000, addr});
      check("w_fields", w_log[$], {ws, wd});
    end
    @(negedge clk); #1;
    check("rsp_pulse", {irsp_valid, drsp_valid}, 2'b00);
    if (wr && !bad) rmem[addr] = merge(rd_ref(addr), wd, ws);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, c;
    logic [31:0] a;
    logic [1:0]  rs;
    logic        ii, ww;
    reset = 0; ireq_valid = 0; ireq_addr = 0;
    dreq_valid = 0; dreq_write = 0; dreq_addr = 0; dreq_wdata = 0; dreq_wstrb = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {arvalid, awvalid, wvalid, rready, bready, irsp_valid, drsp_valid,
                         ireq_ready, dreq_ready}, 9'h0);
    check("reset_addr", {araddress, awaddress}, 64'h0);
    check("reset_data", {wdata, wrstrb, arprot, awprot}, 42'h0);
    @(negedge clk) reset = 1;

    // Instruction fetch from a zero-wait slave.
    run_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 2'b00);

    // Simultaneous requests: data first, instruction waits and follows.
    n = ar_log.size();
    @(negedge clk);
    ireq_valid = 1; ireq_addr = 32'h100;
    dreq_valid = 1; dreq_write = 0; dreq_addr = 32'h200;
    #1;
    check("prio_ready", {dreq_ready, ireq_ready}, 2'b10);
    @(negedge clk) dreq_valid = 0;
    #1;
    c = 1; a = 0;
    while (!drsp_valid && c < 50) begin
      a += 32'(ireq_ready); @(negedge clk); #1; c++;
    end
    check("prio_d_lat", c, 3);
    check("prio_d_data", drsp_data, rd_ref(32'h200));
    check("prio_i_held", a, 0);
    @(negedge clk); #1;
    check("prio_i_ready", ireq_ready, 1'b1);
    @(negedge clk) ireq_valid = 0;
    #1;
    c = 1;
    while (!irsp_valid && c < 50) begin
      @(negedge clk); #1; c++;
    end
    check("prio_i_lat", c, 3);
    check("prio_i_data", irsp_data, rd_ref(32'h100));
    check("prio_order0", ar_log[n], {3'b000, 32'h200});
    check("prio_order1", ar_log[n+1], {3'b101, 32'h100});

    // Store with late awready, then read back to confirm byte enables.
    cfg_aw_d = 2;
    run_req(1'b0, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 2'b00);
    cfg_aw_d = 0;
    run_req(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 2'b00);

    // Slave error response, EXOKAY, and misaligned requests.
    run_req(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 2'b10);
    run_req(1'b0, 1'b0, 32'h404, 32'h0, 4'h0, 2'b01);
    run_req(1'b0, 1'b0, 32'h102, 32'h0, 4'h0, 2'b00);
    run_req(1'b0, 1'b1, 32'h301, 32'h1234_5678, 4'hF, 2'b00);
    run_req(1'b1, 1'b0, 32'h103, 32'h0, 4'h0, 2'b00);

    // Reset in the middle of a read data phase abandons the transaction.
    cfg_r_d = 40;
    @(negedge clk);
    dreq_valid = 1; dreq_write = 0; dreq_addr = 32'h40;
    #1;
    check("rst_accept", dreq_ready, 1'b1);
    @(negedge clk) dreq_valid = 0;
    #1;
    c = 0;
    while (!rready && c < 20) begin
      @(negedge clk); #1; c++;
    end
    check("rst_in_r", rready, 1'b1);
    reset = 0;
    @(posedge clk); #1;
    check("rst_mid_ctrl", {arvalid, rready, irsp_valid, drsp_valid}, 4'h0);
    check("rst_mid_addr", araddress, 32'h0);
    @(negedge clk);
    @(negedge clk) reset = 1;
    c = 0;
    repeat (6) begin
      @(negedge clk); #1; c += int'(irsp_valid) + int'(drsp_valid);
    end
    check("rst_no_rsp", c, 0);
    cfg_r_d = 0;
    run_req(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 2'b00);

`ifdef AXIL_MEM_TIMEOUT_EN
    // Slave never accepts the read address: watchdog fires.
    cfg_ar_d = 100000;
    n = ar_log.size();
    @(negedge clk);
    ireq_valid = 1; ireq_addr = 32'h80;
    #1;
    check("to_accept", ireq_ready, 1'b1);
    @(negedge clk) ireq_valid = 0;
    #1;
    c = 1; a = 0;
    while (!irsp_valid && c < 100) begin
      a += 32'(arvalid); @(negedge clk); #1; c++;
    end
    check("to_latency", c, 18);
    check("to_ar_cycles", a, 16);
    check("to_rsp", {irsp_err, irsp_data}, {1'b1, 32'h0});
    check("to_no_bus", ar_log.size() - n, 0);
    @(negedge clk); #1;
    check("to_idle", {arvalid, irsp_valid}, 2'b00);
    cfg_ar_d = 0;
`endif

    // Randomized traffic with random slave latencies and response codes.
    for (int k = 0; k < 40; k++) begin
      cfg_ar_d = $urandom_range(0, 3); cfg_r_d = $urandom_range(0, 3);
      cfg_aw_d = $urandom_range(0, 3); cfg_w_d = $urandom_range(0, 3);
      cfg_b_d  = $urandom_range(0, 3);
      c  = $urandom_range(0, 9);
      rs = (c < 6) ? 2'b00 : (c < 8) ? 2'b01 : (c == 8) ? 2'b10 : 2'b11;
      ii = ($urandom_range(0, 3) == 0);
      ww = !ii && ($urandom_range(0, 1) == 1);
      a  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      run_req(ii, ww, a, $urandom, 4'($urandom_range(0, 15)), rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_mem_master.md
# axil_mem_master

Parametrised AXI4-lite master that serves the core's instruction-fetch and data load/store ports over a single bus interface. It arbitrates between the two request channels, with data taking priority, and runs one transaction at a time through read or write handshakes. It returns one response per request, carrying data and an error flag, and sits between the core pipeline and the system interconnect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64
- TIMEOUT_CYCLES, 255, watchdog limit (only with the macro)

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- ireq_valid / ireq_ready  in/out  1  instruction request handshake
- ireq_addr  in  ADDR_W  fetch address
- irsp_valid  out  1  one-cycle instruction response
- irsp_data  out  DATA_W  fetched word
- irsp_err  out  1  fetch failed
- dreq_valid / dreq_ready  in/out  1  data request handshake
- dreq_write  in  1  1 = store, 0 = load
- dreq_addr  in  ADDR_W  data address
- dreq_wdata  in  DATA_W  store data
- dreq_wstrb  in  DATA_W/8  store byte enables
- drsp_valid  out  1  one-cycle data response
- drsp_data  out  DATA_W  load data; 0 for stores
- drsp_err  out  1  access failed
- awvalid/awready, awaddress[ADDR_W], awprot[3]  AXI write address channel
- wvalid/wready, wdata[DATA_W], wrstrb[DATA_W/8]  AXI write data channel
- bvalid (in), bready (out), bresp[2]  AXI write response channel
- arvalid/arready, araddress[ADDR_W], arprot[3]  AXI read address channel
- rvalid (in), rready (out), rdata[DATA_W], rresp[2]  AXI read data channel

## Operation
- States: IDLE, AR, R, AW_W, B, RSP.
- IDLE:
  - If dreq_valid, accept data: dreq_ready=1 that cycle.
  - Else if ireq_valid, accept instruction: ireq_ready=1.
  - Both valid: data wins; instruction waits, no drop.
  - Ready outputs are combinational: high only in IDLE, only for the winning channel.
- Latch addr, wdata, strb, write flag and source on accept.
- Misaligned accept (addr mod DATA_W/8 ≠ 0): go straight to RSP with err=1, data=0; no bus traffic.
- Reads: AR drives arvalid=1 and araddress. arprot=3'b101 for instruction, 3'b000 for data.
  - On arready go to R.
  - R holds rready=1. On rvalid, capture rdata and rresp, go to RSP.
- Writes: AW_W drives awvalid and wvalid together, each dropped independently on its own ready.
  - When both handshakes are done, go to B.
  - B holds bready=1. On bvalid, capture bresp, go to RSP.
- Response codes: OKAY(00) and EXOKAY(01) give err=0. Any other code gives err=1 and data=0.
- RSP: raise the source's rsp_valid for exactly one cycle with data/err, then go to IDLE. No backpressure on responses.
- Only one transaction is outstanding at any time.
- Reset (reset=0), including mid-transaction:
  - State goes to IDLE.
  - All valid/ready/rsp outputs go to 0; data and address outputs go to 0; arprot/awprot go to 3'b000.
  - The interrupted transaction is abandoned with no response.

## Timing
- Accept at cycle 0.
- arvalid (or awvalid+wvalid) is high from cycle 1 until its handshake completes.
- Zero-wait slave: read rsp_valid at cycle 3, write rsp_valid at cycle 3.
- Misaligned request: rsp_valid at cycle 1.
- Next accept can occur at earliest one cycle after rsp_valid.
- araddress, awaddress, wdata and wrstrb stay stable while their valid is high.

## Configuration
- AXIL_MEM_TIMEOUT_EN defined: an 8..32-bit counter runs in AR, R, AW_W and B.
  - It resets on every state change.
  - On reaching TIMEOUT_CYCLES, drop all AXI valids/readies, go to RSP with err=1 and data=0.
- AXIL_MEM_TIMEOUT_EN undefined: no counter exists, and the block waits indefinitely.

## Test plan
- Instruction read, zero-wait slave, rdata=0x00000013, rresp=00 -> arprot=3'b101; irsp_valid at cycle 3 with data 0x00000013, err=0.
- ireq and dreq load both valid at 0x100/0x200 -> data served first (araddress=0x200, arprot=000); instruction follows with araddress=0x100.
- Store 0xDEADBEEF, wrstrb=4'b0011; awready 2 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid after 3; drsp_valid one cycle after bvalid, drsp_data=0.
- Load with rresp=2'b10 -> drsp_err=1, drsp_data=0. Load at addr 0x102 -> drsp_err=1 at cycle 1 with no arvalid.
- Reset pulsed while in R -> next cycle arvalid=rready=0, state IDLE, no rsp_valid. A subsequent request completes normally.
- With AXIL_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops and irsp_err=1 pulses 17 cycles after entering AR.
